muldiv_seq: RTL and testbench

//  Iterative 32x32 multiply/divide sequencer that time-shares one 32-bit add/sub datapath (m=1,Cin=1 subtract).

---
 rtl/muldiv_seq_pkg.sv | 41 ++++
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_addsub.sv | 22 ++
 rtl/muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants, op/state encodings and a carry-free negate helper for muldiv_seq.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: WIDTH/CNT_W, op_e encodings, state_e encodings, neg2c().
// Config macro: MULDIV_SIGNED_EN adds the FIX state to state_e.
package muldiv_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_DIVU = 2'b01,
    OP_MUL  = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
`ifdef MULDIV_SIGNED_EN
    ST_FIX  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement negate without a carry chain: a bit flips once any
  // lower bit is set. Keeps the add/sub unit the only adder in the block.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    logic             seen;
    r    = '0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[i] ^ seen;
      seen = seen | x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the issue stage and muldiv_seq.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on request, out_valid/out_ready on result.
// master = requester (issue stage), slave = muldiv_seq.
interface muldiv_seq_if;

  logic                             in_valid;
  logic                             in_ready;
  logic [1:0]                       in_op;
  logic [muldiv_seq_pkg::WIDTH-1:0] in_a;
  logic [muldiv_seq_pkg::WIDTH-1:0] in_b;
  logic                             out_valid;
  logic                             out_ready;
  logic [muldiv_seq_pkg::WIDTH-1:0] out_hi;
  logic [muldiv_seq_pkg::WIDTH-1:0] out_lo;
  logic                             out_dz;
  logic                             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_dz, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_dz, busy
  );

endinterface

// File: rtl/muldiv_addsub.sv
// Shared 32-bit add/sub: sum = a + (m ? ~b : b) + cin, cf = carry-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; m subtract select; cin carry-in; sum result; cf carry flag.
module muldiv_addsub
  import muldiv_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cf
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, (m ? ~b : b)} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cf   = full[WIDTH];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32x32 shift-add multiply / restoring divide on one shared add/sub unit.
// Latency: unsigned result 33 cycles after accept, signed 34, divide-by-zero 1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (muldiv_seq_if.slave: request, result, busy).
// Config macro: MULDIV_SIGNED_EN enables signed ops 10/11 and the FIX state;
// without it ops 10/11 run as MULU/DIVU.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, divisor;
  logic             is_div, dz;
  logic [CNT_W-1:0] count;

  // Incoming request decode
  op_e              op_in;
  logic             in_div, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Shared adder hookup
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_m, add_cin, add_cf;
  logic             quo_bit;

  assign op_in  = op_e'(bus.in_op);
  assign in_div = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign b_zero = (bus.in_b == '0);

`ifdef MULDIV_SIGNED_EN
  logic is_sgn, neg_res, neg_rem;
  logic in_sgn;

  assign in_sgn = (op_in == OP_MUL) || (op_in == OP_DIV);
  // 0x8000_0000 maps to itself, which is its correct unsigned magnitude.
  assign a_mag  = (in_sgn && bus.in_a[WIDTH-1]) ? neg2c(bus.in_a) : bus.in_a;
  assign b_mag  = (in_sgn && bus.in_b[WIDTH-1]) ? neg2c(bus.in_b) : bus.in_b;
`else
  assign a_mag  = bus.in_a;
  assign b_mag  = bus.in_b;
`endif

  always_comb begin
    add_a   = hi;
    add_b   = lo[0] ? divisor : '0;
    add_m   = 1'b0;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
      add_b   = divisor;
      add_m   = 1'b1;
      add_cin = 1'b1;
    end
`ifdef MULDIV_SIGNED_EN
    if (state == ST_FIX) begin
      // Quotient: 0 - lo. Product high half: ~hi + (lo == 0), i.e. the
      // borrow-propagating top half of a 64-bit negate; the low half is
      // negated carry-free alongside it.
      add_a   = '0;
      add_m   = 1'b1;
      add_b   = is_div ? lo : hi;
      add_cin = is_div ? 1'b1 : (lo == '0);
    end
`endif
  end

  muldiv_addsub u_addsub (
    .a   (add_a),
    .b   (add_b),
    .m   (add_m),
    .cin (add_cin),
    .sum (add_sum),
    .cf  (add_cf)
  );

  // The partial remainder is 32 bits, so the bit shifted out of rem[31]
  // is the 33rd bit of the trial dividend; if set, the subtract always fits.
  assign quo_bit = add_cf | hi[WIDTH-1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid) state_nxt = (in_div && b_zero) ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (count == CNT_W'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
          state_nxt = is_sgn ? ST_FIX : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_FIX:  state_nxt = ST_DONE;
`endif
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      is_div  <= 1'b0;
      dz      <= 1'b0;
      count   <= '0;
`ifdef MULDIV_SIGNED_EN
      is_sgn  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            count   <= '0;
            is_div  <= in_div;
            divisor <= b_mag;
            dz      <= in_div && b_zero;
            if (in_div && b_zero) begin
              hi <= bus.in_a;
              lo <= '1;
            end else begin
              // MUL {hi,lo}={0,a} and DIV {rem,quo}={0,a} share one load.
              hi <= '0;
              lo <= a_mag;
            end
`ifdef MULDIV_SIGNED_EN
            is_sgn  <= in_sgn;
            neg_res <= in_sgn && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
            neg_rem <= in_sgn && bus.in_a[WIDTH-1];
`endif
          end
        end
        ST_CALC: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            hi <= quo_bit ? add_sum : add_a;
            lo <= {lo[WIDTH-2:0], quo_bit};
          end else begin
            {hi, lo} <= {add_cf, add_sum, lo[WIDTH-1:1]};
          end
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          if (is_div) begin
            if (neg_res) lo <= add_sum;
            if (neg_rem) hi <= neg2c(hi);
          end else if (neg_res) begin
            hi <= add_sum;
            lo <= neg2c(lo);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_hi    = hi;
  assign bus.out_lo    = lo;
  assign bus.out_dz    = dz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a plain-arithmetic model.
// Covers reset values, directed corner cases, backpressure, mid-operation reset, random ops.
// Honors MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {dz, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic               sgn;
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] up;
    logic signed [31:0] a32, b32, q32, r32;
    sgn = SGN && op[1];
    if (!op[0]) begin
      if (sgn) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        return {1'b0, sp};
      end
      up = {32'h0, a} * {32'h0, b};
      return {1'b0, up};
    end
    if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!sgn) return {1'b0, a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    a32 = a;
    b32 = b;
    q32 = a32 / b32;
    r32 = a32 % b32;
    return {1'b0, r32, q32};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [64:0] exp;
    int          lat_exp;
    int          k;
    logic        rdy_seen;
    logic        stable;
    logic [31:0] h0, l0;
    logic        d0;
    exp = model(op, a, b);
    if (op[0] && b == 32'h0)  lat_exp = 1;
    else if (SGN && op[1])    lat_exp = 34;
    else                      lat_exp = 33;

    check_eq({tag, "_in_ready"}, {63'h0, bus.in_ready}, 64'h1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    check_eq({tag, "_busy"}, {63'h0, bus.busy}, 64'h1);

    k        = 1;
    rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    if (bus.out_valid !== 1'b1) begin
      check_eq({tag, "_timeout"}, 64'h0, 64'h1);
      return;
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(lat_exp));
    check_eq({tag, "_rdy_low_calc"}, {63'h0, rdy_seen}, 64'h0);
    check_eq({tag, "_hi"}, {32'h0, bus.out_hi}, {32'h0, exp[63:32]});
    check_eq({tag, "_lo"}, {32'h0, bus.out_lo}, {32'h0, exp[31:0]});
    check_eq({tag, "_dz"}, {63'h0, bus.out_dz}, {63'h0, exp[64]});

    h0     = bus.out_hi;
    l0     = bus.out_lo;
    d0     = bus.out_dz;
    stable = 1'b1;
    bus.in_valid = 1'b1;  // must not be accepted while a result waits
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_hi !== h0 ||
          bus.out_lo !== l0 || bus.out_dz !== d0)
        stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) check_eq({tag, "_held"}, {63'h0, stable}, 64'h1);

    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_handoff"}, {62'h0, bus.out_valid, bus.in_ready}, 64'h1);
    check_eq({tag, "_hold_res"}, {bus.out_hi, bus.out_lo}, {h0, l0});
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b0;

    #12;
    check_eq("rst_in_ready",  {63'h0, bus.in_ready},  64'h1);
    check_eq("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check_eq("rst_busy",      {63'h0, bus.busy},      64'h0);
    check_eq("rst_out_dz",    {63'h0, bus.out_dz},    64'h0);
    check_eq("rst_out_hilo",  {bus.out_hi, bus.out_lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mulu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    run_op("divu_dz",   2'b01, 32'd5, 32'd0, 0);
    run_op("div_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("mul_m3_5",  2'b10, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_dz",    2'b11, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("divu_big",  2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("mul_bp",    2'b10, 32'h1234_5678, 32'h8765_4321, 10);

    // Reset in the middle of a calculation
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b00;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_state", {61'h0, bus.out_valid, bus.busy, bus.in_ready}, 64'h1);
    check_eq("midrst_hilo",  {bus.out_hi, bus.out_lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_idle", {62'h0, bus.out_valid, bus.in_ready}, 64'h1);
    run_op("after_rst", 2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d", i), op, a, b, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
